// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring_monitor block.
package ring_pkg;

  // FSM: whether a legal reference position is currently held
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  // Classification of the move between two consecutive legal samples
  typedef enum logic [1:0] {
    STEP_NONE  = 2'd0,
    STEP_LEFT  = 2'd1,
    STEP_RIGHT = 2'd2,
    STEP_JUMP  = 2'd3
  } step_t;

  // Index width for an n-bit one-hot word
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ring_monitor_onehot_encoder.sv
// One-hot to binary encoder with an exact popcount==1 legality check.
// idx is meaningless when legal is low (it is the OR of all set positions).
module onehot_encoder
  import ring_pkg::*;
#(
  parameter int N = 8,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] word,
  output logic [W-1:0] idx,
  output logic         legal
);

  logic [W:0] cnt;

  // OR together the positions of all set bits and count them
  always_comb begin
    idx = '0;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      idx = idx | (word[i] ? W'(i) : W'(0));
      cnt = cnt + {{W{1'b0}}, word[i]};
    end
    legal = (cnt == (W+1)'(1));
  end

endmodule

// File: rtl/ring_monitor.sv
// Sampling monitor for a rotating one-hot bus: position readout, step
// classification, signed revolution count and sticky error detection.
module ring_monitor
  import ring_pkg::*;
#(
  parameter int N  = 8,
  parameter int RW = 8,
  localparam int W = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  ring,
  input  logic          err_clr,
  input  logic          rev_clr,
  output logic [W-1:0]  index,
  output logic          locked,
  output logic          onehot_ok,
  output logic          step_left,
  output logic          step_right,
  output logic          jump,
  output logic          wrap,
  output logic          err,
  output logic [RW-1:0] rev_count
);

  localparam logic [W:0] N_EXT = (W+1)'(N);

  state_t     state;
  step_t      step_cls;
  logic [W-1:0] enc_idx;
  logic         enc_legal;
  logic [W:0]   diff_sum;
  logic [W:0]   diff;
  logic         at_top;
  logic         at_bot;

  onehot_encoder #(.N(N)) u_enc (
    .word  (ring),
    .idx   (enc_idx),
    .legal (enc_legal)
  );

  // Modular distance (new - held) mod N; operands are < N so one
  // conditional subtract brings the W+1 bit sum back into range
  always_comb begin
    diff_sum = {1'b0, enc_idx} + N_EXT - {1'b0, index};
    if (diff_sum >= N_EXT) begin
      diff = diff_sum - N_EXT;
    end else begin
      diff = diff_sum;
    end
    at_top = (index == W'(N - 1));
    at_bot = (index == W'(0));
  end

  // Classify the step; N >= 3 keeps +1 and N-1 distinct
  always_comb begin
    if (diff == (W+1)'(0)) begin
      step_cls = STEP_NONE;
    end else if (diff == (W+1)'(1)) begin
      step_cls = STEP_LEFT;
    end else if (diff == N_EXT - (W+1)'(1)) begin
      step_cls = STEP_RIGHT;
    end else begin
      step_cls = STEP_JUMP;
    end
  end

  // Lock FSM with registered position, flags, pulses and revolution count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= UNLOCKED;
      index      <= '0;
      locked     <= 1'b0;
      onehot_ok  <= 1'b0;
      step_left  <= 1'b0;
      step_right <= 1'b0;
      jump       <= 1'b0;
      wrap       <= 1'b0;
      err        <= 1'b0;
      rev_count  <= '0;
    end else begin
      step_left  <= 1'b0;
      step_right <= 1'b0;
      jump       <= 1'b0;
      wrap       <= 1'b0;

      if (en) begin
        onehot_ok <= enc_legal;
        case (state)
          UNLOCKED: begin
            if (enc_legal) begin
              state  <= LOCKED;
              locked <= 1'b1;
              index  <= enc_idx;
            end else begin
              state  <= UNLOCKED;
              locked <= 1'b0;
            end
          end
          LOCKED: begin
            if (enc_legal) begin
              index <= enc_idx;
              case (step_cls)
                STEP_LEFT: begin
                  step_left <= 1'b1;
                  wrap      <= at_top;
                end
                STEP_RIGHT: begin
                  step_right <= 1'b1;
                  wrap       <= at_bot;
                end
                STEP_JUMP: begin
                  jump <= 1'b1;
                end
                default: begin
                  jump <= 1'b0;
                end
              endcase
            end else begin
              state  <= UNLOCKED;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= UNLOCKED;
            locked <= 1'b0;
          end
        endcase
      end else begin
        onehot_ok <= onehot_ok;
      end

      // Clear wins over a simultaneous illegal sample
      if (err_clr) begin
        err <= 1'b0;
      end else if (en && !enc_legal) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end

      // Clear wins over a simultaneous wrap; count wraps modulo 2^RW
      if (rev_clr) begin
        rev_count <= '0;
      end else if (en && enc_legal && (state == LOCKED) &&
                   (step_cls == STEP_LEFT) && at_top) begin
        rev_count <= rev_count + RW'(1);
      end else if (en && enc_legal && (state == LOCKED) &&
                   (step_cls == STEP_RIGHT) && at_bot) begin
        rev_count <= rev_count - RW'(1);
      end else begin
        rev_count <= rev_count;
      end
    end
  end

endmodule

// File: tb/tb_ring_monitor.sv
// Scoreboard bench for ring_monitor: a driver issues samples and pushes the
// expected response from a position-level model; a monitor pops and compares.
module tb_ring_monitor;

  localparam int N  = 8;
  localparam int RW = 8;
  localparam int W  = 3;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [N-1:0]  ring;
  logic          err_clr;
  logic          rev_clr;
  logic [W-1:0]  index;
  logic          locked;
  logic          onehot_ok;
  logic          step_left;
  logic          step_right;
  logic          jump;
  logic          wrap;
  logic          err;
  logic [RW-1:0] rev_count;

  ring_monitor #(.N(N), .RW(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ring       (ring),
    .err_clr    (err_clr),
    .rev_clr    (rev_clr),
    .index      (index),
    .locked     (locked),
    .onehot_ok  (onehot_ok),
    .step_left  (step_left),
    .step_right (step_right),
    .jump       (jump),
    .wrap       (wrap),
    .err        (err),
    .rev_count  (rev_count)
  );

  typedef struct {
    int   idx;
    bit   lck;
    bit   ok;
    bit   sl;
    bit   sr;
    bit   jmp;
    bit   wrp;
    bit   er;
    int   rev;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   pushes = 0;
  int   pops   = 0;

  // Model state: plain position/flags, revolution count as an integer mod 256
  int m_pos;
  bit m_locked;
  bit m_ok;
  bit m_err;
  int m_rev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function void chk(string name, int act, int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  function void model_reset();
    m_pos = 0; m_locked = 0; m_ok = 0; m_err = 0; m_rev = 0;
  endfunction

  // Apply one clock's inputs to the model and return the expected outputs
  function exp_t model_step(bit e, logic [N-1:0] r, bit ec, bit rc);
    exp_t x;
    int   p;
    int   d;
    bit   legal;
    x.sl = 0; x.sr = 0; x.jmp = 0; x.wrp = 0;
    legal = ($countones(r) == 1);
    if (e) begin
      m_ok = legal;
      if (legal) begin
        p = 0;
        for (int i = 0; i < N; i++) if (r[i]) p = i;
        if (m_locked) begin
          d = (p - m_pos + N) % N;
          if (d == 1) begin
            x.sl = 1;
            if (m_pos == N - 1) begin x.wrp = 1; m_rev = (m_rev + 1) % 256; end
          end else if (d == N - 1) begin
            x.sr = 1;
            if (m_pos == 0) begin x.wrp = 1; m_rev = (m_rev + 255) % 256; end
          end else if (d != 0) begin
            x.jmp = 1;
          end
        end
        m_pos = p;
        m_locked = 1;
      end else begin
        m_locked = 0;
      end
    end
    if (rc) m_rev = 0;
    if (ec) m_err = 0;
    else if (e && !legal) m_err = 1;
    x.idx = m_pos; x.lck = m_locked; x.ok = m_ok; x.er = m_err; x.rev = m_rev;
    return x;
  endfunction

  task automatic step(bit e, logic [N-1:0] r, bit ec, bit rc);
    @(negedge clk);
    rst_n   = 1'b1;
    en      = e;
    ring    = r;
    err_clr = ec;
    rev_clr = rc;
    q.push_back(model_step(e, r, ec, rc));
    pushes++;
  endtask

  // Asynchronous reset between edges; outputs must drop before the next edge
  task automatic mid_reset();
    exp_t z;
    @(negedge clk);
    en = 1'b1; ring = 8'h01; err_clr = 1'b0; rev_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_index", int'(index), 0);
    chk("async_locked", int'(locked), 0);
    chk("async_rev", int'(rev_count), 0);
    chk("async_err", int'(err), 0);
    chk("async_ok", int'(onehot_ok), 0);
    model_reset();
    z.idx = 0; z.lck = 0; z.ok = 0; z.sl = 0; z.sr = 0; z.jmp = 0;
    z.wrp = 0; z.er = 0; z.rev = 0;
    q.push_back(z);
    pushes++;
  endtask

  // Monitor: after every edge compare the DUT against the oldest expectation
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        pops++;
        chk("index", int'(index), x.idx);
        chk("locked", int'(locked), int'(x.lck));
        chk("onehot_ok", int'(onehot_ok), int'(x.ok));
        chk("step_left", int'(step_left), int'(x.sl));
        chk("step_right", int'(step_right), int'(x.sr));
        chk("jump", int'(jump), int'(x.jmp));
        chk("wrap", int'(wrap), int'(x.wrp));
        chk("err", int'(err), int'(x.er));
        chk("rev_count", int'(rev_count), x.rev);
      end
    end
  end

  // Driver: directed scenarios then randomized samples
  initial begin
    logic [N-1:0] r;
    int k;
    rst_n = 1'b0; en = 1'b0; ring = '0; err_clr = 1'b0; rev_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    step(0, 8'h80, 0, 0);           // reset state visible
    step(1, 8'h80, 0, 0);           // lock at 7, no pulse
    step(1, 8'h01, 0, 0);           // left wrap, rev=1
    step(1, 8'h02, 0, 0);           // left
    step(1, 8'h01, 0, 1);           // right, clear rev
    step(1, 8'h80, 0, 0);           // right wrap, rev=FF
    step(1, 8'h40, 0, 0);           // right
    step(1, 8'h00, 0, 0);           // illegal: unlock, err
    step(1, 8'h03, 0, 0);           // still unlocked
    step(1, 8'h04, 0, 0);           // relock at 2, no pulse
    step(1, 8'h04, 0, 0);           // hold
    step(1, 8'h04, 1, 0);           // err_clr
    step(1, 8'h02, 0, 0);           // right to 1
    step(1, 8'h20, 0, 0);           // jump to 5
    step(1, 8'h20, 0, 0);
    step(1, 8'h20, 0, 0);
    step(1, 8'h20, 0, 0);           // held, no pulses
    step(0, 8'h40, 0, 0);           // frozen
    step(0, 8'h11, 0, 0);           // frozen despite illegal word
    step(1, 8'h80, 0, 0);           // jump to 7
    step(1, 8'h01, 0, 1);           // left wrap with rev_clr
    step(1, 8'h06, 1, 0);           // illegal with err_clr
    step(1, 8'h01, 0, 0);           // relock
    step(1, 8'h02, 0, 0);
    mid_reset();
    step(1, 8'h04, 0, 0);           // first sample after reset only locks
    step(1, 8'h08, 0, 0);

    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 11);
      case (k)
        0, 1, 2, 3: begin r = '0; r[(m_pos + 1) % N] = 1'b1; end
        4, 5, 6:    begin r = '0; r[(m_pos + N - 1) % N] = 1'b1; end
        7:          begin r = '0; r[m_pos] = 1'b1; end
        8:          begin r = '0; r[$urandom_range(0, N - 1)] = 1'b1; end
        9:          r = '0;
        default:    r = N'($urandom);
      endcase
      step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, r,
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", pops, pushes);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ring_monitor.md
# ring_monitor

Sampling monitor for the one-hot output of a ring counter: the receiving end of a rotating one-hot bus. Each enabled cycle it encodes the one-hot word to a binary index, checks it for legality, classifies the step since the previous legal sample (left, right, hold, jump) and keeps a signed revolution count. It sits downstream of a ring counter, or any one-hot sequencer, for position readout and fault detection.

## Interface
- N, 8: ring width; legal range N ≥ 3.
- RW, 8: revolution counter width.
- W (localparam), $clog2(N): index width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  sample enable; when low, all state holds and all pulses are 0.
- ring  in  N  one-hot word under observation.
- err_clr  in  1  synchronous clear of the sticky err flag.
- rev_clr  in  1  synchronous clear of rev_count.
- index  out  W  position of the last legal sample.
- locked  out  1  a legal sample has been seen since the last reset or illegal sample.
- onehot_ok  out  1  the last enabled sample was exactly one-hot.
- step_left  out  1  pulse: index advanced by +1 mod N (bit i moved to i+1).
- step_right  out  1  pulse: index moved by −1 mod N.
- jump  out  1  pulse: legal sample with any other nonzero index change.
- wrap  out  1  pulse: left step from N−1 to 0, or right step from 0 to N−1.
- err  out  1  sticky flag: an illegal sample (zero bits or more than one bit set) was seen.
- rev_count  out  RW  revolution count, modulo 2^RW.

## Operation
- Reset values: index=0, locked=0, onehot_ok=0, err=0, rev_count=0, all pulses 0, FSM in UNLOCKED.
- FSM states:
  - UNLOCKED → LOCKED on the first enabled legal sample. index loads the encoded value. No step, jump or wrap pulse is issued for this sample.
  - LOCKED stays LOCKED on each legal sample. Each such sample is classified against the held index:
    - +1 mod N: step_left.
    - −1 mod N: step_right.
    - equal: no pulse (hold).
    - otherwise: jump.
    - index updates in every case.
  - LOCKED → UNLOCKED on any enabled illegal sample. On this transition err is set, onehot_ok=0, and index holds its previous value.
  - An illegal sample in UNLOCKED also sets err and leaves the FSM in UNLOCKED.
- wrap asserts together with step_left or step_right on the boundary cases.
  - Left wrap: rev_count + 1.
  - Right wrap: rev_count − 1.
  - rev_count wraps silently modulo 2^RW in both directions.
- Priorities:
  - rev_clr beats a simultaneous wrap: rev_count becomes 0.
  - err_clr beats a simultaneous illegal sample: err becomes 0, but that sample still forces UNLOCKED.
- The legality check is exact popcount==1. With N ≥ 3, a +1 step and a −1 step are never ambiguous.

## Timing
- All outputs are registered.
- One-cycle latency: ring sampled at edge k with en=1 → index, flags and pulses valid after edge k.
- Pulses last exactly one cycle per enabled sample. A ring that holds its value for several cycles produces no pulses after the first.
- en=0 at edge k: pulses are 0 after k, all other outputs hold.
- err_clr and rev_clr act only at a rising edge and are independent of en.
- rst_n assertion mid-operation clears everything immediately, without waiting for clk. Deassertion is synchronized externally. The first legal sample after release only locks.

## Structure
- Package ring_pkg holds:
  - the state enum {UNLOCKED, LOCKED};
  - the step-class enum {STEP_NONE, STEP_LEFT, STEP_RIGHT, STEP_JUMP};
  - the function computing W from N.
- Sub-module onehot_encoder:
  - purely combinational, parameter N;
  - outputs: idx[W−1:0] and legal (popcount==1);
  - when the input is illegal, idx is don't-care.
- ring_monitor holds:
  - the FSM;
  - the modular step classifier: compares (idx − index) mod N against 1 and N−1, with no arithmetic wider than W+1;
  - the revolution counter;
  - the sticky error flag.

## Test plan
- Reset, then en=1 with ring=8'h80 → after 1 edge: locked=1, index=7, no pulses.
- Left rotation 0x80→0x01→0x02 → step_left on each edge; wrap=1 and rev_count=1 on the 0x80→0x01 edge.
- Right rotation 0x01→0x80→0x40 → step_right on each edge; wrap on 0x01→0x80; rev_count decrements from 0 to 8'hFF.
- Illegal words:
  - ring=0x00 → err=1, locked=0, index held, onehot_ok=0.
  - then ring=0x03 → still unlocked.
  - then 0x04 → relocks with index=2 and no pulse.
  - err stays 1 until err_clr.
- Jump and hold:
  - locked at index 1, ring 0x02→0x20 → jump=1, index=5.
  - holding 0x20 for 3 cycles → no pulses.
  - en=0 while ring changes → all outputs frozen.
- Simultaneous events:
  - rev_clr on the same edge as a left wrap → rev_count=0.
  - rst_n pulsed low mid-rotation between edges → outputs return to reset values immediately.
